// File: rtl/fc_stream_feeder_if.sv
// rtl/fc_stream_feeder_if.sv - serial FP32 feature stream with valid/ready handshake
interface fc_stream_feeder_if;
  logic        s_valid;
  logic        s_ready;
  logic [31:0] s_data;

  modport master (output s_valid, output s_data, input s_ready);
  modport slave  (input s_valid, input s_data, output s_ready);
endinterface

// File: rtl/fc_stream_feeder.sv
// rtl/fc_stream_feeder.sv - streams a weight store to an FC layer, then packs serial features into frames
module fc_stream_feeder #(
  parameter int N_IN = 16
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 wr_en,
  input  logic [3:0]           wr_addr,
  input  logic [31:0]          wr_w0,
  input  logic [31:0]          wr_w1,
  input  logic                 go,
  output logic                 load_weight,
  output logic [31:0]          weight0,
  output logic [31:0]          weight1,
  input  logic                 load_weight_done,
  fc_stream_feeder_if.slave    feat,
  output logic [31:0]          data_out0,
  output logic [31:0]          data_out1,
  output logic [31:0]          data_out2,
  output logic [31:0]          data_out3,
  output logic [31:0]          data_out4,
  output logic [31:0]          data_out5,
  output logic [31:0]          data_out6,
  output logic [31:0]          data_out7,
  output logic [31:0]          data_out8,
  output logic [31:0]          data_out9,
  output logic [31:0]          data_out10,
  output logic [31:0]          data_out11,
  output logic [31:0]          data_out12,
  output logic [31:0]          data_out13,
  output logic [31:0]          data_out14,
  output logic [31:0]          data_out15,
  output logic                 valid_in,
  output logic                 start,
  input  logic                 fc_valid,
  output logic                 weights_ready,
  output logic                 busy
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    LOAD     = 2'd1,
    WAIT_ACK = 2'd2,
    READY    = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [4:0]  row_q, row_d;
  logic        lw_d;
  logic [31:0] w0_d, w1_d;

  logic [31:0] w0_mem [N_IN];
  logic [31:0] w1_mem [N_IN];

  logic [31:0] vec_q [16];
  logic [3:0]  idx_q;
  logic        xfer;
  logic        last_word;

  // Weight store has no reset: the host may preload it at any time, even in reset.
  always_ff @(posedge clk) begin
    if (wr_en && ({1'b0, wr_addr} < 5'(N_IN))) begin
      w0_mem[wr_addr] <= wr_w0;
      w1_mem[wr_addr] <= wr_w1;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= IDLE;
      row_q       <= '0;
      load_weight <= 1'b0;
      weight0     <= '0;
      weight1     <= '0;
    end else begin
      state_q     <= state_d;
      row_q       <= row_d;
      load_weight <= lw_d;
      weight0     <= w0_d;
      weight1     <= w1_d;
    end
  end

  // row_q is the next row to fetch, so load_weight is high exactly while in LOAD.
  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    lw_d    = 1'b0;
    w0_d    = '0;
    w1_d    = '0;
    case (state_q)
      IDLE: begin
        if (go) begin
          state_d = LOAD;
          lw_d    = 1'b1;
          w0_d    = w0_mem[0];
          w1_d    = w1_mem[0];
          row_d   = 5'd1;
        end
      end
      LOAD: begin
        if (row_q == 5'(N_IN)) begin
          state_d = WAIT_ACK;
          row_d   = '0;
        end else begin
          lw_d  = 1'b1;
          w0_d  = w0_mem[row_q[3:0]];
          w1_d  = w1_mem[row_q[3:0]];
          row_d = row_q + 5'd1;
        end
      end
      WAIT_ACK: begin
        if (load_weight_done) begin
          state_d = READY;
        end
      end
      READY: begin
        state_d = READY;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign weights_ready = (state_q == READY);
  assign feat.s_ready  = (state_q == READY) && !busy;
  assign xfer          = feat.s_valid && feat.s_ready;
  assign last_word     = (idx_q == 4'(N_IN - 1));

  // start trails valid_in by one cycle so the consumer multiplies its registered copy.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      idx_q    <= '0;
      valid_in <= 1'b0;
      start    <= 1'b0;
      busy     <= 1'b0;
      for (int k = 0; k < 16; k++) begin
        vec_q[k] <= '0;
      end
    end else begin
      valid_in <= 1'b0;
      start    <= valid_in;
      if (xfer) begin
        vec_q[idx_q] <= feat.s_data;
        if (last_word) begin
          idx_q    <= '0;
          valid_in <= 1'b1;
          busy     <= 1'b1;
        end else begin
          idx_q <= idx_q + 4'd1;
        end
      end else if (busy && fc_valid) begin
        busy <= 1'b0;
      end
    end
  end

  assign data_out0  = vec_q[0];
  assign data_out1  = vec_q[1];
  assign data_out2  = vec_q[2];
  assign data_out3  = vec_q[3];
  assign data_out4  = vec_q[4];
  assign data_out5  = vec_q[5];
  assign data_out6  = vec_q[6];
  assign data_out7  = vec_q[7];
  assign data_out8  = vec_q[8];
  assign data_out9  = vec_q[9];
  assign data_out10 = vec_q[10];
  assign data_out11 = vec_q[11];
  assign data_out12 = vec_q[12];
  assign data_out13 = vec_q[13];
  assign data_out14 = vec_q[14];
  assign data_out15 = vec_q[15];

endmodule

// File: tb/tb_fc_stream_feeder.sv
// tb/tb_fc_stream_feeder.sv - scoreboard bench for fc_stream_feeder
module tb_fc_stream_feeder;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        wr_en = 1'b0;
  logic [3:0]  wr_addr = '0;
  logic [31:0] wr_w0 = '0;
  logic [31:0] wr_w1 = '0;
  logic        go = 1'b0;
  logic        load_weight;
  logic [31:0] weight0, weight1;
  logic        load_weight_done = 1'b0;
  logic [31:0] dout [16];
  logic        valid_in, start, weights_ready, busy;
  logic        fc_valid = 1'b0;

  fc_stream_feeder_if feat ();

  always #5 clk = ~clk;

  fc_stream_feeder #(.N_IN(16)) dut (
    .clk(clk), .resetn(resetn),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_w0(wr_w0), .wr_w1(wr_w1),
    .go(go), .load_weight(load_weight), .weight0(weight0), .weight1(weight1),
    .load_weight_done(load_weight_done), .feat(feat),
    .data_out0(dout[0]), .data_out1(dout[1]), .data_out2(dout[2]), .data_out3(dout[3]),
    .data_out4(dout[4]), .data_out5(dout[5]), .data_out6(dout[6]), .data_out7(dout[7]),
    .data_out8(dout[8]), .data_out9(dout[9]), .data_out10(dout[10]), .data_out11(dout[11]),
    .data_out12(dout[12]), .data_out13(dout[13]), .data_out14(dout[14]), .data_out15(dout[15]),
    .valid_in(valid_in), .start(start), .fc_valid(fc_valid),
    .weights_ready(weights_ready), .busy(busy)
  );

  int checks = 0;
  int errors = 0;
  int rows_seen = 0;

  logic [31:0]  m_w0 [16];
  logic [31:0]  m_w1 [16];
  logic [63:0]  exp_rows [$];
  logic [511:0] exp_frames [$];
  logic         prev_vi = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
    end
  endtask

  // Monitor: every weight row and every frame the DUT presents is checked against the queues.
  always @(negedge clk) begin
    logic [63:0]  er;
    logic [511:0] ef;
    if (!resetn) begin
      prev_vi = 1'b0;
    end else begin
      chk("start_after_valid_in", {63'd0, start}, {63'd0, prev_vi});
      if (load_weight) begin
        if (exp_rows.size() == 0) begin
          chk("unexpected_load_weight", 64'd1, 64'd0);
        end else begin
          er = exp_rows.pop_front();
          chk("weight0_row", {32'd0, weight0}, {32'd0, er[63:32]});
          chk("weight1_row", {32'd0, weight1}, {32'd0, er[31:0]});
          rows_seen++;
        end
      end else begin
        chk("weights_zero_when_idle", {weight0, weight1}, 64'd0);
      end
      if (valid_in) begin
        if (exp_frames.size() == 0) begin
          chk("unexpected_valid_in", 64'd1, 64'd0);
        end else begin
          ef = exp_frames.pop_front();
          for (int k = 0; k < 16; k++) begin
            chk($sformatf("data_out%0d", k), {32'd0, dout[k]}, {32'd0, ef[k*32 +: 32]});
          end
          chk("busy_at_valid_in", {63'd0, busy}, 64'd1);
        end
      end
      prev_vi = valid_in;
    end
  end

  task automatic write_row(input int r, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    wr_en   = 1'b1;
    wr_addr = 4'(r);
    wr_w0   = a;
    wr_w1   = b;
    m_w0[r] = a;
    m_w1[r] = b;
    @(posedge clk);
    #1 wr_en = 1'b0;
  endtask

  task automatic pulse_go(input bit expect_load);
    @(negedge clk);
    rows_seen = 0;
    if (expect_load) begin
      for (int r = 0; r < 16; r++) exp_rows.push_back({m_w0[r], m_w1[r]});
    end
    go = 1'b1;
    @(negedge clk);
    go = 1'b0;
  endtask

  task automatic send_frame(input logic [511:0] f, input int mode);
    int  i = 0;
    int  cyc = 0;
    bit  x;
    exp_frames.push_back(f);
    while (i < 16 && cyc < 400) begin
      @(negedge clk);
      feat.s_data = f[i*32 +: 32];
      case (mode)
        0:       feat.s_valid = (cyc % 2 == 0);
        1:       feat.s_valid = 1'($urandom_range(0, 1));
        default: feat.s_valid = 1'b1;
      endcase
      x = feat.s_valid && feat.s_ready;
      @(posedge clk);
      if (x) i++;
      cyc++;
    end
    #1 feat.s_valid = 1'b0;
    if (i < 16) chk("frame_transfer_timeout", 64'd0, 64'd1);
  endtask

  task automatic wait_valid_in();
    bit found = 1'b0;
    for (int k = 0; k < 10 && !found; k++) begin
      @(negedge clk);
      if (valid_in) found = 1'b1;
    end
    if (!found) chk("valid_in_timeout", 64'd0, 64'd1);
  endtask

  task automatic fc_pulse_check_clear();
    fc_valid = 1'b1;
    @(negedge clk);
    fc_valid = 1'b0;
    chk("busy_clears_after_fc_valid", {63'd0, busy}, 64'd0);
    chk("s_ready_after_fc_valid", {63'd0, feat.s_ready}, 64'd1);
  endtask

  task automatic ack_weights();
    repeat (10) begin
      @(negedge clk);
      chk("wait_ack_s_ready", {63'd0, feat.s_ready}, 64'd0);
      chk("wait_ack_weights_ready", {63'd0, weights_ready}, 64'd0);
      go = ($urandom_range(0, 2) == 0);
    end
    @(negedge clk);
    go = 1'b0;
    load_weight_done = 1'b1;
    @(negedge clk);
    load_weight_done = 1'b0;
    chk("weights_ready_after_ack", {63'd0, weights_ready}, 64'd1);
    chk("s_ready_after_ack", {63'd0, feat.s_ready}, 64'd1);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_load_weight"}, {63'd0, load_weight}, 64'd0);
    chk({tag, "_weights"}, {weight0, weight1}, 64'd0);
    chk({tag, "_valid_in"}, {63'd0, valid_in}, 64'd0);
    chk({tag, "_start"}, {63'd0, start}, 64'd0);
    chk({tag, "_s_ready"}, {63'd0, feat.s_ready}, 64'd0);
    chk({tag, "_busy"}, {63'd0, busy}, 64'd0);
    chk({tag, "_weights_ready"}, {63'd0, weights_ready}, 64'd0);
    chk({tag, "_data_out0"}, {32'd0, dout[0]}, 64'd0);
    chk({tag, "_data_out15"}, {32'd0, dout[15]}, 64'd0);
  endtask

  initial begin
    logic [511:0] f;
    bit           hit;
    feat.s_valid = 1'b0;
    feat.s_data  = '0;

    repeat (3) @(negedge clk);
    check_all_zero("reset");
    #2 resetn = 1'b1;

    for (int r = 0; r < 16; r++) write_row(r, 32'h3F80_0000 + 32'(r), 32'h4000_0000 + 32'(r));
    pulse_go(1'b1);
    repeat (18) @(negedge clk);
    chk("rows_drained", 64'(exp_rows.size()), 64'd0);

    ack_weights();
    pulse_go(1'b0);
    repeat (3) @(negedge clk);

    for (int k = 0; k < 16; k++) f[k*32 +: 32] = 32'h3F80_0000;
    send_frame(f, 0);
    wait_valid_in();
    feat.s_valid = 1'b1;
    feat.s_data  = $urandom;
    repeat (4) begin
      @(negedge clk);
      chk("s_ready_while_busy", {63'd0, feat.s_ready}, 64'd0);
      chk("busy_held", {63'd0, busy}, 64'd1);
    end
    chk("data_out_held", {32'd0, dout[5]}, {32'd0, 32'h3F80_0000});
    feat.s_valid = 1'b0;
    fc_pulse_check_clear();

    for (int k = 0; k < 16; k++) f[k*32 +: 32] = $urandom;
    send_frame(f, 1);
    wait_valid_in();
    @(negedge clk);
    fc_pulse_check_clear();
    fc_valid = 1'b1;
    @(negedge clk);
    fc_valid = 1'b0;
    chk("fc_valid_idle_ignored", {63'd0, busy}, 64'd0);

    for (int k = 0; k < 16; k++) f[k*32 +: 32] = $urandom;
    send_frame(f, 2);
    wait_valid_in();
    repeat (3) @(negedge clk);
    fc_pulse_check_clear();

    for (int r = 0; r < 16; r++) write_row(r, $urandom, $urandom);
    pulse_go(1'b0);
    repeat (2) @(negedge clk);
    chk("go_in_ready_no_load", 64'(exp_rows.size()), 64'd0);

    // Reset is released and a fresh load is cut at row 7.
    @(negedge clk);
    #2 resetn = 1'b0;
    @(negedge clk);
    #2 resetn = 1'b1;
    pulse_go(1'b1);
    hit = 1'b0;
    for (int k = 0; k < 30 && !hit; k++) begin
      @(negedge clk);
      #2 if (rows_seen == 8) hit = 1'b1;
    end
    if (!hit) chk("row7_timeout", 64'd0, 64'd1);
    resetn = 1'b0;
    #1 check_all_zero("mid_load_reset");
    exp_rows.delete();
    @(negedge clk);
    #2 resetn = 1'b1;
    for (int r = 0; r < 4; r++) write_row(r, $urandom, $urandom);
    pulse_go(1'b1);
    repeat (18) @(negedge clk);
    chk("rows_drained_after_reset", 64'(exp_rows.size()), 64'd0);
    ack_weights();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fc_stream_feeder.md
FC_STREAM_FEEDER -- requirements
Module: fc_stream_feeder

Interface
REQ-001 Parameter N_IN, default 16, number of FP32 features per frame and number of weight rows streamed.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 resetn  input  1  asynchronous, active-low reset.
REQ-004 wr_en  input  1  host write strobe into the internal weight store.
REQ-005 wr_addr  input  4  weight store row index, 0..N_IN-1.
REQ-006 wr_w0, wr_w1  input  32 each  FP32 weights for class 0 / class 1 at wr_addr.
REQ-007 go  input  1  one-cycle request to stream the weight store to the FC layer.
REQ-008 load_weight  output  1  high while weight0/weight1 carry a valid row.
REQ-009 weight0, weight1  output  32 each  FP32 weight row currently streamed.
REQ-010 load_weight_done  input  1  FC layer's level acknowledge that all rows were captured.
REQ-011 s_valid, s_ready, s_data[31:0]  input/output/input  1/1/32  serial FP32 feature stream, valid/ready.
REQ-012 data_out0..data_out15  output  32 each  packed feature vector toward the FC layer.
REQ-013 valid_in  output  1  one-cycle strobe: data_out bus stable and to be captured.
REQ-014 start  output  1  one-cycle strobe launching the FC multipliers.
REQ-015 fc_valid  input  1  FC layer result-valid pulse.
REQ-016 weights_ready  output  1  high once the acknowledge has been received.
REQ-017 busy  output  1  high from frame launch until fc_valid.

Function
REQ-018 Weight store: 2 x N_IN x 32-bit registers, written on any cycle with wr_en=1, independent of state; no reset of contents.
REQ-019 Control FSM states IDLE, LOAD, WAIT_ACK, READY.
REQ-020 IDLE: go=1 -> LOAD with row index 0; go in any other state is ignored.
REQ-021 LOAD: load_weight=1 for exactly N_IN consecutive cycles; in cycle k weight0/weight1 = store row k (k=0..N_IN-1); after row N_IN-1 -> WAIT_ACK.
REQ-022 weight0/weight1 are registered outputs, 0 whenever load_weight=0.
REQ-023 A wr_en to a row in the same cycle that row is streamed: old value is streamed.
REQ-024 WAIT_ACK: load_weight=0; load_weight_done=1 -> READY; no timeout.
REQ-025 READY is terminal until reset (the consumer's row counter clears only on reset); weights_ready=1 in READY.
REQ-026 s_ready=1 only in READY, with busy=0, and fewer than N_IN words collected.
REQ-027 Each s_valid&s_ready transfer writes s_data to data_out[idx], idx increments 0..N_IN-1.
REQ-028 Transfer of word N_IN-1: next cycle valid_in=1; following cycle start=1 (start strictly one cycle after valid_in so the consumer's registered data is used); idx returns to 0; busy=1 from the valid_in cycle.
REQ-029 data_out bus holds its value from valid_in until the next frame's first transfer.
REQ-030 busy clears on the cycle after fc_valid=1; fc_valid while busy=0 is ignored.
REQ-031 fc_valid in the same cycle as start: busy still clears next cycle.
REQ-032 s_valid with s_ready=0: no transfer, s_data ignored, idx unchanged.

Reset
REQ-033 resetn=0 asynchronously forces state IDLE, idx 0, load_weight 0, weight0/weight1 0, valid_in 0, start 0, s_ready 0, busy 0, weights_ready 0, data_out* 0.
REQ-034 Reset mid-LOAD or mid-frame abandons the operation; a new go is required after release.

Verification
REQ-035 Write rows r: w0=0x3F800000+r, w1=0x40000000+r; pulse go -> load_weight high 16 cycles, rows 0..15 in order, then low.
REQ-036 Hold load_weight_done=0 for 10 cycles after LOAD -> stays WAIT_ACK, s_ready=0; raise it -> weights_ready=1, s_ready=1 next cycle.
REQ-037 Stream 16 words 0x3F800000 with s_valid toggling every other cycle -> all 16 captured in order, valid_in one cycle, start exactly one cycle later.
REQ-038 With busy=1, present s_valid=1 -> s_ready=0, no capture; pulse fc_valid -> busy=0, s_ready=1 next cycle.
REQ-039 Assert resetn=0 on LOAD row 7 -> all outputs 0 immediately; after release go restarts from row 0.
REQ-040 go pulsed in READY and during WAIT_ACK -> no load_weight activity.
